sort_buffer: RTL and testbench

//   Parametrised stack/queue buffer. Loads entries under op commands, then on a sort command

---
 rtl/sort_buffer_pkg.sv | 20 ++
 rtl/sort_cmp_swap.sv | 42 ++++
 rtl/sort_buffer.sv | 221 ++++++++++++++++++++++
 tb/tb_sort_buffer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sort_buffer_pkg.sv
// Shared definitions for the sort buffer: command codes, FSM states, storage modes.
package sort_buffer_pkg;

  typedef enum logic [1:0] {
    OP_POP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_SORT = 2'd2,
    OP_NOP  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SORT = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam logic MODE_STACK = 1'b0;
  localparam logic MODE_QUEUE = 1'b1;

endpackage

// File: rtl/sort_cmp_swap.sv
// Compare-exchange cell. When enabled, orders the pair (a at the lower index, b at the
// higher index) so that the lower index holds the smaller value (larger when desc).
// Equal values are never exchanged, so the sort is stable.
module sort_cmp_swap
  import sort_buffer_pkg::*;
#(
  parameter int DATA_W = 5
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              desc,
  input  logic              en,
  output logic [DATA_W-1:0] lo_out,
  output logic [DATA_W-1:0] hi_out
);

  logic swap_s;

  // Decide whether the pair is out of order and route it accordingly.
  always_comb begin
    swap_s = 1'b0;
    lo_out = a;
    hi_out = b;
    if (en) begin
      if (desc) begin
        swap_s = (a < b);
      end else begin
        swap_s = (a > b);
      end
    end else begin
      swap_s = 1'b0;
    end
    if (swap_s) begin
      lo_out = b;
      hi_out = a;
    end else begin
      lo_out = a;
      hi_out = b;
    end
  end

endmodule

// File: rtl/sort_buffer.sv
// Stack/queue buffer that loads entries, sorts them with an odd-even transposition
// network (one phase per cycle) and streams the valid entries out, buf[0] first.
module sort_buffer
  import sort_buffer_pkg::*;
#(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic              cfg_mode,
  input  logic              cfg_desc,
  input  logic              in_valid,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] in,
  output logic              busy,
  output logic              full,
  output logic              empty,
  output logic              err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out,
  output logic              out_last
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PH_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1'b1);

  state_e              state_r, state_nxt_s;
  logic [CNT_W-1:0]    count_r, out_idx_r;
  logic [PH_W-1:0]     phase_r;
  logic [DATA_W-1:0]   buf_r [DEPTH];
  logic [DATA_W-1:0]   net_s [DEPTH];
  logic [DATA_W-1:0]   lo_s  [DEPTH-1];
  logic [DATA_W-1:0]   hi_s  [DEPTH-1];
  logic [DEPTH-2:0]    cell_en_s;
  logic                mode_r, desc_r;
  logic                err_r, out_valid_r, out_last_r;
  logic [DATA_W-1:0]   out_r;
  logic                full_s, empty_s, last_phase_s;

  assign full_s       = (count_r == CNT_W'(DEPTH));
  assign empty_s      = (count_r == {CNT_W{1'b0}});
  assign last_phase_s = (phase_r == PH_W'(DEPTH - 1));

  assign busy      = (state_r != ST_LOAD);
  assign full      = full_s;
  assign empty     = empty_s;
  assign err       = err_r;
  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign out_last  = out_last_r;

  // One cell per adjacent pair; even phases use pairs starting at even indices, odd
  // phases those starting at odd indices. Pairs touching an empty slot stay idle.
  for (genvar g = 0; g < DEPTH - 1; g++) begin : g_cell
    assign cell_en_s[g] = (state_r == ST_SORT) && (phase_r[0] == 1'(g % 2)) &&
                          (CNT_W'(g + 1) < count_r);
    sort_cmp_swap #(.DATA_W(DATA_W)) u_cell (
      .a      (buf_r[g]),
      .b      (buf_r[g+1]),
      .desc   (desc_r),
      .en     (cell_en_s[g]),
      .lo_out (lo_s[g]),
      .hi_out (hi_s[g])
    );
  end

  // Gather the buffer image after the current phase; disabled cells pass data through.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      net_s[j] = buf_r[j];
    end
    net_s[0] = cell_en_s[0] ? lo_s[0] : buf_r[0];
    for (int j = 1; j < DEPTH - 1; j++) begin
      net_s[j] = cell_en_s[j] ? lo_s[j] : (cell_en_s[j-1] ? hi_s[j-1] : buf_r[j]);
    end
    net_s[DEPTH-1] = cell_en_s[DEPTH-2] ? hi_s[DEPTH-2] : buf_r[DEPTH-1];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: LOAD until sort, DEPTH sort phases, then stream unless empty.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (in_valid && (op == OP_SORT)) begin
          state_nxt_s = ST_SORT;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_SORT: begin
        if (last_phase_s) begin
          state_nxt_s = empty_s ? ST_LOAD : ST_OUT;
        end else begin
          state_nxt_s = ST_SORT;
        end
      end
      ST_OUT: begin
        if (out_idx_r == count_r) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: state_nxt_s = ST_LOAD;
    endcase
  end

  // Storage, configuration, sort phase counter and registered output stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r     <= {CNT_W{1'b0}};
      out_idx_r   <= {CNT_W{1'b0}};
      phase_r     <= {PH_W{1'b0}};
      mode_r      <= MODE_STACK;
      desc_r      <= 1'b0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_r       <= {DATA_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        buf_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_LOAD: begin
          if (cfg_valid) begin
            mode_r <= cfg_mode;
            desc_r <= cfg_desc;
          end
          if (in_valid) begin
            case (op)
              OP_PUSH: begin
                if (full_s) begin
                  err_r <= 1'b1;
                end else begin
                  buf_r[count_r] <= in;
                  count_r        <= count_r + CNT_ONE;
                end
              end
              OP_POP: begin
                if (empty_s) begin
                  err_r <= 1'b1;
                end else if (mode_r == MODE_QUEUE) begin
                  for (int i = 0; i < DEPTH - 1; i++) begin
                    buf_r[i] <= buf_r[i+1];
                  end
                  buf_r[DEPTH-1] <= {DATA_W{1'b0}};
                  count_r        <= count_r - CNT_ONE;
                end else begin
                  buf_r[count_r - CNT_ONE] <= {DATA_W{1'b0}};
                  count_r                  <= count_r - CNT_ONE;
                end
              end
              OP_SORT: phase_r <= {PH_W{1'b0}};
              default: ;
            endcase
          end
        end
        ST_SORT: begin
          if (in_valid) begin
            err_r <= 1'b1;
          end
          for (int i = 0; i < DEPTH; i++) begin
            buf_r[i] <= net_s[i];
          end
          phase_r <= phase_r + PH_ONE;
          // The first entry leaves straight from the final phase so the stream has no gap.
          if (last_phase_s) begin
            phase_r <= {PH_W{1'b0}};
            if (!empty_s) begin
              out_r       <= net_s[0];
              out_valid_r <= 1'b1;
              out_last_r  <= (count_r == CNT_ONE);
              out_idx_r   <= CNT_ONE;
            end
          end
        end
        ST_OUT: begin
          if (in_valid) begin
            err_r <= 1'b1;
          end
          if (out_idx_r != count_r) begin
            out_r       <= buf_r[out_idx_r];
            out_valid_r <= 1'b1;
            out_last_r  <= (out_idx_r == (count_r - CNT_ONE));
            out_idx_r   <= out_idx_r + CNT_ONE;
          end else begin
            out_r       <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_idx_r   <= {CNT_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
              buf_r[i] <= {DATA_W{1'b0}};
            end
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          out_r       <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_buffer.sv
// Directed bench for sort_buffer: a reference model of the buffer contents builds the
// expected sorted stream into a scoreboard queue, which is popped as entries appear.
module tb_sort_buffer;
  import sort_buffer_pkg::*;

  localparam int DW = 5;
  localparam int D  = 10;

  logic          clk = 1'b0;
  logic          rst, cfg_valid, cfg_mode, cfg_desc, in_valid;
  logic [1:0]    op;
  logic [DW-1:0] in_d;
  logic          busy, full, empty, err, out_valid, out_last;
  logic [DW-1:0] out_d;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mdl_q[$];
  logic [DW-1:0] exp_q[$];
  logic          mdl_mode = 1'b0;
  logic          mdl_desc = 1'b0;

  sort_buffer #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_desc(cfg_desc),
    .in_valid(in_valid), .op(op), .in(in_d), .busy(busy), .full(full), .empty(empty),
    .err(err), .out_valid(out_valid), .out(out_d), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cfg(input logic m, input logic d);
    cfg_valid = 1'b1; cfg_mode = m; cfg_desc = d;
    cyc;
    cfg_valid = 1'b0;
    mdl_mode = m; mdl_desc = d;
  endtask

  task automatic do_push(input logic [DW-1:0] v, input string tag);
    logic exp_err;
    exp_err = (mdl_q.size() == D);
    in_valid = 1'b1; op = 2'd1; in_d = v;
    cyc;
    in_valid = 1'b0; op = 2'd3;
    if (!exp_err) mdl_q.push_back(v);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_full"}, full, mdl_q.size() == D);
  endtask

  // Pop, optionally with a cfg update on the same edge (the pop must use the old mode).
  task automatic do_pop(input string tag, input logic with_cfg, input logic m, input logic d);
    logic exp_err;
    exp_err = (mdl_q.size() == 0);
    in_valid = 1'b1; op = 2'd0;
    cfg_valid = with_cfg; cfg_mode = m; cfg_desc = d;
    cyc;
    in_valid = 1'b0; op = 2'd3; cfg_valid = 1'b0;
    if (!exp_err) begin
      if (mdl_mode) void'(mdl_q.pop_front());
      else void'(mdl_q.pop_back());
    end
    if (with_cfg) begin
      mdl_mode = m; mdl_desc = d;
    end
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_empty"}, empty, mdl_q.size() == 0);
  endtask

  // Issue sort and check the whole busy window; inject a push during OUT at index inject.
  task automatic run_sort(input string tag, input int inject);
    logic [DW-1:0] arr[$];
    logic [DW-1:0] tmp, e;
    int n;
    arr = mdl_q;
    n = arr.size();
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n - 1 - i; j++) begin
        if (mdl_desc ? (arr[j] < arr[j+1]) : (arr[j] > arr[j+1])) begin
          tmp = arr[j]; arr[j] = arr[j+1]; arr[j+1] = tmp;
        end
      end
    end
    foreach (arr[k]) exp_q.push_back(arr[k]);
    in_valid = 1'b1; op = 2'd2;
    cyc;
    in_valid = 1'b0; op = 2'd3;
    chk({tag, "_busy0"}, busy, 1'b1);
    chk({tag, "_err0"}, err, 1'b0);
    for (int j = 1; j < D; j++) begin
      cyc;
      chk({tag, "_sort_busy"}, busy, 1'b1);
      chk({tag, "_sort_ov"}, out_valid, 1'b0);
    end
    for (int i = 0; i < n; i++) begin
      if (i == inject) begin
        in_valid = 1'b1; op = 2'd1; in_d = 5'd21;
      end
      cyc;
      in_valid = 1'b0; op = 2'd3;
      chk({tag, "_ov"}, out_valid, 1'b1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'd0;
      chk({tag, "_data"}, out_d, e);
      chk({tag, "_last"}, out_last, i == n - 1);
      if (i == inject) chk({tag, "_inj_err"}, err, 1'b1);
    end
    cyc;
    chk({tag, "_done_busy"}, busy, 1'b0);
    chk({tag, "_done_ov"}, out_valid, 1'b0);
    chk({tag, "_done_out"}, out_d, 5'd0);
    chk({tag, "_done_empty"}, empty, 1'b1);
    chk({tag, "_sb_left"}, exp_q.size(), 0);
    mdl_q.delete();
  endtask

  initial begin
    logic [DW-1:0] vals[10];
    rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 1'b0; cfg_desc = 1'b0;
    in_valid = 1'b0; op = 2'd3; in_d = 5'd0;
    cyc; cyc;
    chk("rst_busy", busy, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_out", out_d, 5'd0);
    chk("rst_last", out_last, 1'b0);
    rst = 1'b0;

    // 1: stack, ascending.
    do_push(5'd3, "t1_p3"); do_push(5'd7, "t1_p7"); do_push(5'd1, "t1_p1");
    do_pop("t1_pop", 1'b0, 1'b0, 1'b0);
    run_sort("t1", -1);

    // 2: queue, descending.
    do_cfg(1'b1, 1'b1);
    do_push(5'd9, "t2_p9"); do_push(5'd4, "t2_p4"); do_push(5'd6, "t2_p6");
    do_pop("t2_pop", 1'b0, 1'b0, 1'b0);
    run_sort("t2", -1);

    // 3: fill, overflow, full ascending sort; 5a: push rejected during OUT.
    do_cfg(1'b0, 1'b0);
    vals = '{5'd31, 5'd0, 5'd17, 5'd3, 5'd9, 5'd22, 5'd14, 5'd8, 5'd27, 5'd5};
    for (int i = 0; i < D; i++) do_push(vals[i], "t3_fill");
    chk("t3_full10", full, 1'b1);
    do_push(5'd12, "t3_over");
    cyc;
    chk("t3_err_clear", err, 1'b0);
    chk("t3_still_full", full, 1'b1);
    run_sort("t3", 2);

    // 4: pop on empty, sort on empty.
    do_pop("t4_pop_empty", 1'b0, 1'b0, 1'b0);
    cyc;
    chk("t4_err_pulse", err, 1'b0);
    chk("t4_empty", empty, 1'b1);
    run_sort("t4", -1);

    // 5b: cfg to queue on the same edge as a pop -> the pop still behaves as a stack.
    do_push(5'd1, "t5_p1"); do_push(5'd2, "t5_p2"); do_push(5'd3, "t5_p3");
    do_pop("t5_pop_cfg", 1'b1, 1'b1, 1'b0);
    run_sort("t5", -1);

    // 6: reset in the middle of the output stream.
    do_push(5'd8, "t6_p8"); do_push(5'd3, "t6_p3");
    in_valid = 1'b1; op = 2'd2;
    cyc;
    in_valid = 1'b0; op = 2'd3;
    repeat (D) cyc;
    chk("t6_pre_ov", out_valid, 1'b1);
    rst = 1'b1;
    cyc;
    chk("t6_rst_ov", out_valid, 1'b0);
    chk("t6_rst_empty", empty, 1'b1);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_last", out_last, 1'b0);
    rst = 1'b0;
    mdl_q.delete(); mdl_mode = 1'b0; mdl_desc = 1'b0;
    do_push(5'd5, "t6_p5"); do_push(5'd9, "t6_p9");
    do_pop("t6_pop", 1'b0, 1'b0, 1'b0);
    run_sort("t6", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
